pb_step_pulser: RTL and testbench

- Upstream stage for the shift/rotate LED register; its `step` output drives that register's shift enable in place of a raw push-button clock.
- Conditioning chain on the 10 MHz board clock: 2-flop synchronizer → debouncer → press-edge one-shot → optional hold-to-auto-repeat.
- Also provides a wrapping step counter for display on seven-segment or LEDs.

---
 rtl/pb_step_pulser.sv | 121 ++++++++++++
 tb/tb_pb_step_pulser.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_step_pulser.sv
// Push-button conditioner: synchronizer, debouncer, press one-shot with optional
// hold-to-auto-repeat, plus a wrapping count of the step pulses issued.
module pb_step_pulser #(
  parameter int DEB_CYCLES = 100000,
  parameter int RPT_DELAY  = 5000000,
  parameter int RPT_PERIOD = 1000000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pb_raw,
  input  logic             rpt_en,
  output logic             pb_level,
  output logic             step,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMR_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(RPT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic             s1_r;
  logic             s2_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [TMR_W-1:0] timer_r;
  state_t           state_r;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= pb_raw;
      s2_r <= s1_r;
    end
  end

  // Debouncer: level follows only after DEB_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_level  <= 1'b0;
      deb_cnt_r <= '0;
    end else if (s2_r == pb_level) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_LAST) begin
      pb_level  <= s2_r;
      deb_cnt_r <= '0;
    end else begin
      deb_cnt_r <= deb_cnt_r + DEB_W'(1);
    end
  end

  // Step FSM: press pulse, initial repeat delay, then periodic repeat; release wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      timer_r  <= '0;
      step     <= 1'b0;
      step_cnt <= '0;
    end else begin
      step <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          timer_r <= '0;
          if (pb_level) begin
            step     <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
            state_r  <= ST_DELAY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!pb_level) begin
            timer_r <= '0;
            state_r <= ST_IDLE;
          end else if (!rpt_en) begin
            timer_r <= '0;
          end else if (timer_r == DLY_LAST) begin
            step     <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
            timer_r  <= '0;
            state_r  <= ST_REPEAT;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!pb_level) begin
            timer_r <= '0;
            state_r <= ST_IDLE;
          end else if (!rpt_en) begin
            timer_r <= '0;
          end else if (timer_r == PER_LAST) begin
            step     <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
            timer_r  <= '0;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: begin
          timer_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_step_pulser.sv
// Directed bench for pb_step_pulser with short debounce/repeat parameters.
module tb_pb_step_pulser;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int CW  = 8;

  logic          clk;
  logic          reset;
  logic          pb_raw;
  logic          rpt_en;
  logic          pb_level;
  logic          step;
  logic [CW-1:0] step_cnt;

  int total;
  int bad;

  pb_step_pulser #(
    .DEB_CYCLES(DEB),
    .RPT_DELAY (DLY),
    .RPT_PERIOD(PER),
    .CNT_W     (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pb_raw  (pb_raw),
    .rpt_en  (rpt_en),
    .pb_level(pb_level),
    .step    (step),
    .step_cnt(step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    pb_raw = 1'b0;
    rpt_en = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    pb_raw = 1'b0;
    rpt_en = 1'b0;
    tick;
    tick;
    total++;
    if ({pb_level, step, step_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_state got lvl=%b step=%b cnt=%0d exp 0/0/0", pb_level, step, step_cnt);
    end
    reset = 1'b0;
    repeat (10) tick;
    total++;
    if ({pb_level, step, step_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL idle_after_reset got lvl=%b step=%b cnt=%0d exp 0/0/0", pb_level, step, step_cnt);
    end
  endtask

  task automatic test_clean_press;
    int pulses;
    logic exp_b;
    do_reset;
    pb_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick;
      exp_b = (e >= 6);
      total++;
      if (pb_level !== exp_b) begin
        bad++;
        $display("FAIL press_level e=%0d got=%b exp=%b", e, pb_level, exp_b);
      end
      exp_b = (e == 7);
      total++;
      if (step !== exp_b) begin
        bad++;
        $display("FAIL press_step e=%0d got=%b exp=%b", e, step, exp_b);
      end
    end
    pulses = 0;
    repeat (100) begin
      tick;
      if (step === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL hold_no_repeat got=%0d pulses exp=0", pulses);
    end
    total++;
    if (step_cnt !== 8'd1) begin
      bad++;
      $display("FAIL press_cnt got=%0d exp=1", step_cnt);
    end
    pb_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick;
      exp_b = (e < 6);
      total++;
      if (pb_level !== exp_b || step !== 1'b0) begin
        bad++;
        $display("FAIL release e=%0d got lvl=%b step=%b exp lvl=%b step=0", e, pb_level, step, exp_b);
      end
    end
  endtask

  task automatic test_bounce;
    logic [9:0] pat;
    int seen;
    int pulses;
    int pedge;
    pat = 10'b1110110100;
    seen = 0;
    do_reset;
    for (int i = 0; i < 40; i++) begin
      pb_raw = pat[9 - (i % 10)];
      tick;
      if (pb_level === 1'b1 || step === 1'b1) seen++;
    end
    pb_raw = 1'b0;
    repeat (8) begin
      tick;
      if (pb_level === 1'b1 || step === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || step_cnt !== 8'd0) begin
      bad++;
      $display("FAIL bounce_reject got active=%0d cnt=%0d exp 0/0", seen, step_cnt);
    end
    pb_raw = 1'b1;
    pulses = 0;
    pedge = -1;
    for (int e = 1; e <= 30; e++) begin
      tick;
      if (step === 1'b1) begin
        pulses++;
        pedge = e;
      end
    end
    total++;
    if (pulses !== 1 || pedge !== 7 || step_cnt !== 8'd1) begin
      bad++;
      $display("FAIL bounce_then_stable got pulses=%0d edge=%0d cnt=%0d exp 1/7/1", pulses, pedge, step_cnt);
    end
    pb_raw = 1'b0;
    repeat (10) tick;
  endtask

  task automatic test_auto_repeat;
    int fedge;
    logic exp_b;
    do_reset;
    rpt_en = 1'b1;
    pb_raw = 1'b1;
    fedge = -1;
    for (int e = 1; e <= 20; e++) begin
      tick;
      if (step === 1'b1) begin
        fedge = e;
        break;
      end
    end
    total++;
    if (fedge !== 7) begin
      bad++;
      $display("FAIL repeat_first got edge=%0d exp=7", fedge);
    end
    for (int r = 1; r <= 80; r++) begin
      if (r == 54) pb_raw = 1'b0;
      tick;
      exp_b = (r >= 20 && r <= 55 && ((r - 20) % 5) == 0);
      total++;
      if (step !== exp_b) begin
        bad++;
        $display("FAIL repeat_step r=%0d got=%b exp=%b", r, step, exp_b);
      end
      if (r == 58 || r == 59) begin
        exp_b = (r == 58);
        total++;
        if (pb_level !== exp_b) begin
          bad++;
          $display("FAIL repeat_release_lvl r=%0d got=%b exp=%b", r, pb_level, exp_b);
        end
      end
    end
    total++;
    if (step_cnt !== 8'd9) begin
      bad++;
      $display("FAIL repeat_cnt got=%0d exp=9", step_cnt);
    end
  endtask

  task automatic test_rpt_toggle;
    int fedge;
    logic exp_b;
    do_reset;
    rpt_en = 1'b1;
    pb_raw = 1'b1;
    fedge = -1;
    for (int e = 1; e <= 20; e++) begin
      tick;
      if (step === 1'b1) begin
        fedge = e;
        break;
      end
    end
    total++;
    if (fedge !== 7) begin
      bad++;
      $display("FAIL toggle_first got edge=%0d exp=7", fedge);
    end
    for (int r = 1; r <= 50; r++) begin
      if (r == 28) rpt_en = 1'b0;
      if (r == 40) rpt_en = 1'b1;
      tick;
      exp_b = (r == 20 || r == 25 || r == 44 || r == 49);
      total++;
      if (step !== exp_b) begin
        bad++;
        $display("FAIL toggle_step r=%0d got=%b exp=%b", r, step, exp_b);
      end
    end
    total++;
    if (step_cnt !== 8'd5) begin
      bad++;
      $display("FAIL toggle_cnt got=%0d exp=5", step_cnt);
    end
    pb_raw = 1'b0;
    repeat (10) tick;
  endtask

  task automatic test_wrap_reset;
    int n;
    int pulses;
    int pedge;
    do_reset;
    rpt_en = 1'b1;
    pb_raw = 1'b1;
    n = 0;
    while (step_cnt !== 8'd255 && n < 3000) begin
      tick;
      n++;
    end
    total++;
    if (step_cnt !== 8'd255 || step !== 1'b1) begin
      bad++;
      $display("FAIL preload got cnt=%0d step=%b exp 255/1", step_cnt, step);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (step === 1'b1) break;
    end
    total++;
    if (step !== 1'b1 || step_cnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap got step=%b cnt=%0d exp 1/0", step, step_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (step === 1'b1) break;
    end
    total++;
    if (step !== 1'b1 || step_cnt !== 8'd1 || pb_level !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got step=%b cnt=%0d lvl=%b exp 1/1/1", step, step_cnt, pb_level);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({pb_level, step, step_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL async_reset got lvl=%b step=%b cnt=%0d exp 0/0/0", pb_level, step, step_cnt);
    end
    rpt_en = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    pulses = 0;
    pedge = -1;
    for (int e = 1; e <= 30; e++) begin
      tick;
      if (step === 1'b1) begin
        pulses++;
        pedge = e;
      end
    end
    total++;
    if (pulses !== 1 || pedge !== 7 || step_cnt !== 8'd1 || pb_level !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_press got pulses=%0d edge=%0d cnt=%0d lvl=%b exp 1/7/1/1",
               pulses, pedge, step_cnt, pb_level);
    end
    pb_raw = 1'b0;
    repeat (10) tick;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    pb_raw = 1'b0;
    rpt_en = 1'b0;
    test_reset;
    test_clean_press;
    test_bounce;
    test_auto_repeat;
    test_rpt_toggle;
    test_wrap_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
